video_timing_monitor: RTL and testbench

- Pass-through pipeline stage between the HDMI receiver (dvi2rgb) and the HDMI transmitter (rgb2dvi) on PixelClk.
- Delays video by a fixed 2 cycles, replacing the loop's ad-hoc d0/d1 registers.
- Measures incoming timing: active pixels, total pixels, active lines, total lines.
- Asserts a lock flag once the timing is stable over several frames, for resolution reporting and output-gating decisions.

---
 rtl/video_timing_monitor_if.sv | 40 ++++
 rtl/video_timing_monitor.sv | 228 ++++++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/video_timing_monitor_if.sv
// Video stream bundle for the timing monitor: the incoming stream from the
// receiver, the delayed stream to the transmitter and the timing report.
// The monitor uses the slave view; whatever drives the stream and reads the
// report uses the master view.
interface video_timing_monitor_if #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 12
);
  logic [DATA_W-1:0] vid_pData;
  logic              vid_pVDE;
  logic              vid_pHSync;
  logic              vid_pVSync;

  logic [DATA_W-1:0] vid_oData;
  logic              vid_oVDE;
  logic              vid_oHSync;
  logic              vid_oVSync;

  logic [CNT_W-1:0]  h_active;
  logic [CNT_W-1:0]  h_total;
  logic [CNT_W-1:0]  v_active;
  logic [CNT_W-1:0]  v_total;
  logic              timing_locked;
  logic              frame_start;
  logic              timing_changed;

  modport master (
    output vid_pData, vid_pVDE, vid_pHSync, vid_pVSync,
    input  vid_oData, vid_oVDE, vid_oHSync, vid_oVSync,
    input  h_active, h_total, v_active, v_total,
    input  timing_locked, frame_start, timing_changed
  );

  modport slave (
    input  vid_pData, vid_pVDE, vid_pHSync, vid_pVSync,
    output vid_oData, vid_oVDE, vid_oHSync, vid_oVSync,
    output h_active, h_total, v_active, v_total,
    output timing_locked, frame_start, timing_changed
  );
endinterface

// File: rtl/video_timing_monitor.sv
// Two-stage pass-through between HDMI receiver and transmitter that also
// measures the incoming video timing and reports it once it has been
// identical over several consecutive frames.
module video_timing_monitor #(
  parameter int DATA_W        = 24,
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 2,
  parameter bit HS_POL        = 1'b1,
  parameter bit VS_POL        = 1'b1
) (
  input  logic                  PixelClk,
  input  logic                  aRst_n,
  video_timing_monitor_if.slave vif
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [3:0]       STABLE_LIM = 4'(STABLE_FRAMES);

  // One frame's worth of measurements, compared as a whole between frames.
  typedef struct packed {
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] h_tot;
    logic [CNT_W-1:0] v_act;
    logic [CNT_W-1:0] v_tot;
  } cand_t;

  // Counters stick at all-ones so that a runaway count reads as "saturated".
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // A candidate is usable only if every field was really measured.
  function automatic logic cand_ok(input cand_t c);
    cand_ok = (c.h_act != CNT_ZERO) && (c.h_act != CNT_MAX) &&
              (c.h_tot != CNT_ZERO) && (c.h_tot != CNT_MAX) &&
              (c.v_act != CNT_ZERO) && (c.v_act != CNT_MAX) &&
              (c.v_tot != CNT_ZERO) && (c.v_tot != CNT_MAX) &&
              (c.h_act < c.h_tot);
  endfunction

  // Pipeline stages
  logic [DATA_W-1:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic              vde_s1_q, vde_s1_d, vde_s2_q, vde_s2_d;
  logic              hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic              vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic              fs_p1_q, fs_p1_d, frame_start_q, frame_start_d;

  // Measurement counters
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d, act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0]  h_total_m_q, h_total_m_d, h_active_m_q, h_active_m_d;
  logic [CNT_W-1:0]  line_act_q, line_act_d, line_tot_q, line_tot_d;

  // Stability and lock
  logic [3:0]        stable_cnt_q, stable_cnt_d;
  cand_t             prev_cand_q, prev_cand_d;
  logic              prev_valid_q, prev_valid_d;
  logic              locked_q, locked_d, changed_q, changed_d;
  logic [CNT_W-1:0]  h_active_q, h_active_d, h_total_q, h_total_d;
  logic [CNT_W-1:0]  v_active_q, v_active_d, v_total_q, v_total_d;

  // Edge detection against stage 1; syncs are judged at their active level.
  logic  vde_rise, vde_fall, hs_rise, vs_rise, pix_sat;
  logic  cand_match, acquire;
  cand_t cand;

  assign vde_rise = vif.vid_pVDE & ~vde_s1_q;
  assign vde_fall = ~vif.vid_pVDE & vde_s1_q;
  assign hs_rise  = (vif.vid_pHSync == HS_POL) & (hs_s1_q != HS_POL);
  assign vs_rise  = (vif.vid_pVSync == VS_POL) & (vs_s1_q != VS_POL);
  assign pix_sat  = (pix_cnt_q == CNT_MAX);

  assign cand       = '{h_act: h_active_m_q, h_tot: h_total_m_q,
                        v_act: line_act_q,   v_tot: line_tot_q};
  assign cand_match = prev_valid_q && cand_ok(cand) && (cand == prev_cand_q);

  // Fixed two-cycle video delay; frame_start is delayed alongside VSync.
  always_comb begin
    data_s1_d     = vif.vid_pData;
    vde_s1_d      = vif.vid_pVDE;
    hs_s1_d       = vif.vid_pHSync;
    vs_s1_d       = vif.vid_pVSync;
    data_s2_d     = data_s1_q;
    vde_s2_d      = vde_s1_q;
    hs_s2_d       = hs_s1_q;
    vs_s2_d       = vs_s1_q;
    fs_p1_d       = vs_rise;
    frame_start_d = fs_p1_q;
  end

  // Pixel/line counters; a VDE rise at a frame boundary belongs to the new frame.
  always_comb begin
    pix_cnt_d    = vde_rise ? CNT_ONE : sat_inc(pix_cnt_q);
    h_total_m_d  = vde_rise ? pix_cnt_q : h_total_m_q;
    if (vde_rise) begin
      act_cnt_d = CNT_ONE;
    end else if (vif.vid_pVDE) begin
      act_cnt_d = sat_inc(act_cnt_q);
    end else begin
      act_cnt_d = act_cnt_q;
    end
    h_active_m_d = vde_fall ? act_cnt_q : h_active_m_q;
    if (vs_rise) begin
      line_act_d = vde_rise ? CNT_ONE : CNT_ZERO;
      line_tot_d = hs_rise  ? CNT_ONE : CNT_ZERO;
    end else begin
      line_act_d = vde_rise ? sat_inc(line_act_q) : line_act_q;
      line_tot_d = hs_rise  ? sat_inc(line_tot_q) : line_tot_q;
    end
  end

  // Frame-to-frame stability tracking, lock acquisition/loss and the watchdog.
  always_comb begin
    changed_d = locked_q & (pix_sat | (vs_rise & ~cand_match));
    acquire   = ~locked_q & ~vs_rise & ~pix_sat & (stable_cnt_q == STABLE_LIM);
    if (acquire) begin
      locked_d = 1'b1;
    end else if (changed_d) begin
      locked_d = 1'b0;
    end else begin
      locked_d = locked_q;
    end

    if (pix_sat) begin
      stable_cnt_d = 4'd0;
    end else if (vs_rise) begin
      if (cand_match) begin
        stable_cnt_d = (stable_cnt_q == STABLE_LIM) ? stable_cnt_q : stable_cnt_q + 4'd1;
      end else begin
        stable_cnt_d = 4'd0;
      end
    end else begin
      stable_cnt_d = stable_cnt_q;
    end

    if (vs_rise) begin
      prev_cand_d  = cand;
      prev_valid_d = 1'b1;
    end else begin
      prev_cand_d  = prev_cand_q;
      prev_valid_d = prev_valid_q;
    end

    // Reported timing only changes on a new lock; it survives lock loss.
    if (acquire) begin
      h_active_d = prev_cand_q.h_act;
      h_total_d  = prev_cand_q.h_tot;
      v_active_d = prev_cand_q.v_act;
      v_total_d  = prev_cand_q.v_tot;
    end else begin
      h_active_d = h_active_q;
      h_total_d  = h_total_q;
      v_active_d = v_active_q;
      v_total_d  = v_total_q;
    end
  end

  // State register: every flop clears on aRst_n.
  always_ff @(posedge PixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      data_s1_q     <= '0;
      vde_s1_q      <= 1'b0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      data_s2_q     <= '0;
      vde_s2_q      <= 1'b0;
      hs_s2_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      fs_p1_q       <= 1'b0;
      frame_start_q <= 1'b0;
      pix_cnt_q     <= CNT_ZERO;
      act_cnt_q     <= CNT_ZERO;
      h_total_m_q   <= CNT_ZERO;
      h_active_m_q  <= CNT_ZERO;
      line_act_q    <= CNT_ZERO;
      line_tot_q    <= CNT_ZERO;
      stable_cnt_q  <= 4'd0;
      prev_cand_q   <= '0;
      prev_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      changed_q     <= 1'b0;
      h_active_q    <= CNT_ZERO;
      h_total_q     <= CNT_ZERO;
      v_active_q    <= CNT_ZERO;
      v_total_q     <= CNT_ZERO;
    end else begin
      data_s1_q     <= data_s1_d;
      vde_s1_q      <= vde_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      data_s2_q     <= data_s2_d;
      vde_s2_q      <= vde_s2_d;
      hs_s2_q       <= hs_s2_d;
      vs_s2_q       <= vs_s2_d;
      fs_p1_q       <= fs_p1_d;
      frame_start_q <= frame_start_d;
      pix_cnt_q     <= pix_cnt_d;
      act_cnt_q     <= act_cnt_d;
      h_total_m_q   <= h_total_m_d;
      h_active_m_q  <= h_active_m_d;
      line_act_q    <= line_act_d;
      line_tot_q    <= line_tot_d;
      stable_cnt_q  <= stable_cnt_d;
      prev_cand_q   <= prev_cand_d;
      prev_valid_q  <= prev_valid_d;
      locked_q      <= locked_d;
      changed_q     <= changed_d;
      h_active_q    <= h_active_d;
      h_total_q     <= h_total_d;
      v_active_q    <= v_active_d;
      v_total_q     <= v_total_d;
    end
  end

  assign vif.vid_oData      = data_s2_q;
  assign vif.vid_oVDE       = vde_s2_q;
  assign vif.vid_oHSync     = hs_s2_q;
  assign vif.vid_oVSync     = vs_s2_q;
  assign vif.h_active       = h_active_q;
  assign vif.h_total        = h_total_q;
  assign vif.v_active       = v_active_q;
  assign vif.v_total        = v_total_q;
  assign vif.timing_locked  = locked_q;
  assign vif.frame_start    = frame_start_q;
  assign vif.timing_changed = changed_q;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor. Two instances see the same logical
// stream: dut_p with active-high syncs, dut_n with active-low syncs (its sync
// pins are the inverse). Frames are generated starting with the VSync line.
module tb_video_timing_monitor;
  localparam int DW = 24;
  localparam int CW = 12;

  logic PixelClk = 1'b0;
  logic aRst_n;
  always #5 PixelClk = ~PixelClk;

  video_timing_monitor_if #(.DATA_W(DW), .CNT_W(CW)) vif_p ();
  video_timing_monitor_if #(.DATA_W(DW), .CNT_W(CW)) vif_n ();

  video_timing_monitor #(.DATA_W(DW), .CNT_W(CW), .STABLE_FRAMES(2),
                         .HS_POL(1'b1), .VS_POL(1'b1))
    dut_p (.PixelClk(PixelClk), .aRst_n(aRst_n), .vif(vif_p.slave));

  video_timing_monitor #(.DATA_W(DW), .CNT_W(CW), .STABLE_FRAMES(2),
                         .HS_POL(1'b0), .VS_POL(1'b0))
    dut_n (.PixelClk(PixelClk), .aRst_n(aRst_n), .vif(vif_n.slave));

  logic [DW-1:0] data;
  logic          vde, hs_act, vs_act;

  assign vif_p.vid_pData  = data;
  assign vif_p.vid_pVDE   = vde;
  assign vif_p.vid_pHSync = hs_act;
  assign vif_p.vid_pVSync = vs_act;
  assign vif_n.vid_pData  = data;
  assign vif_n.vid_pVDE   = vde;
  assign vif_n.vid_pHSync = ~hs_act;
  assign vif_n.vid_pVSync = ~vs_act;

  int vectors     = 0;
  int miscompares = 0;
  int fs_cnt      = 0;
  int tc_cnt      = 0;
  int fs0, tc0;
  logic ovs_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse counters and frame_start alignment with vid_oVSync going active.
  always @(negedge PixelClk) begin
    if (vif_p.frame_start) fs_cnt++;
    if (vif_p.timing_changed) tc_cnt++;
    if (vif_p.frame_start || (vif_p.vid_oVSync && !ovs_prev))
      check("fs_align", 32'(vif_p.frame_start), 32'(vif_p.vid_oVSync && !ovs_prev));
    ovs_prev = vif_p.vid_oVSync;
  end

  task automatic tick();
    @(posedge PixelClk);
    #1;
  endtask

  // Each cycle's outputs must equal the inputs applied one tick earlier
  // (inputs set just after an edge reach vid_o* two edges later).
  task automatic passthru(input int n, input bit rnd);
    logic [26:0] prev_v, cur_v;
    prev_v = '0;
    for (int i = 0; i < n; i++) begin
      data = DW'($urandom);
      if (rnd) {vde, hs_act, vs_act} = 3'($urandom);
      else     {vde, hs_act, vs_act} = 3'b000;
      cur_v = {vde, hs_act, vs_act, data};
      tick();
      if (i > 0)
        check("passthru", {5'b0, vif_p.vid_oVDE, vif_p.vid_oHSync, vif_p.vid_oVSync, vif_p.vid_oData},
              {5'b0, prev_v});
      prev_v = cur_v;
    end
  endtask

  // One frame starting with the VSync line; active lines are the last vact.
  task automatic send_frame(input int hact, input int htot, input int vact, input int vtot);
    for (int ln = 0; ln < vtot; ln++) begin
      for (int h = 0; h < htot; h++) begin
        data   = DW'($urandom);
        vde    = (ln >= vtot - vact) && (h < hact);
        hs_act = (h == hact + 1) || (h == hact + 2);
        vs_act = (ln == 0) && (h < htot / 2);
        tick();
      end
    end
  endtask

  task automatic check_meas(input string tag, input int ha, input int ht, input int va, input int vt);
    check({tag, "_hact"}, 32'(vif_p.h_active), ha);
    check({tag, "_htot"}, 32'(vif_p.h_total),  ht);
    check({tag, "_vact"}, 32'(vif_p.v_active), va);
    check({tag, "_vtot"}, 32'(vif_p.v_total),  vt);
  endtask

  initial begin
    aRst_n = 1'b0;
    {data, vde, hs_act, vs_act} = '0;

    // 1: outputs held at zero under reset whatever the inputs do
    for (int i = 0; i < 3; i++) begin
      data = DW'($urandom);
      {vde, hs_act, vs_act} = 3'b111;
      tick();
    end
    check("rst_odata", 32'(vif_p.vid_oData), 0);
    check("rst_octl", {29'b0, vif_p.vid_oVDE, vif_p.vid_oHSync, vif_p.vid_oVSync}, 0);
    check("rst_locked", 32'(vif_p.timing_locked), 0);
    check_meas("rst", 0, 0, 0, 0);
    aRst_n = 1'b1;
    passthru(40, 1'b1);
    aRst_n = 1'b0;
    tick();
    tick();
    aRst_n = 1'b1;
    passthru(8, 1'b0);

    // 2: 8/12/4/6 locks at the third boundary that closes a full frame
    fs0 = fs_cnt;
    tc0 = tc_cnt;
    for (int f = 0; f < 3; f++) send_frame(8, 12, 4, 6);
    check("t2_not_yet", 32'(vif_p.timing_locked), 0);
    send_frame(8, 12, 4, 6);
    check("t2_locked", 32'(vif_p.timing_locked), 1);
    check("t2_locked_n", 32'(vif_n.timing_locked), 1);
    check_meas("t2", 8, 12, 4, 6);
    check("t2_fs_count", fs_cnt - fs0, 4);
    check("t2_tc_count", tc_cnt - tc0, 0);

    // 3: v_active becomes 5; lock drops once, reported timing holds, re-lock
    tc0 = tc_cnt;
    send_frame(8, 12, 5, 6);
    check("t3_still_locked", 32'(vif_p.timing_locked), 1);
    send_frame(8, 12, 5, 6);
    check("t3_unlocked", 32'(vif_p.timing_locked), 0);
    check("t3_tc_count", tc_cnt - tc0, 1);
    check_meas("t3_hold", 8, 12, 4, 6);
    send_frame(8, 12, 5, 6);
    check("t3_not_yet", 32'(vif_p.timing_locked), 0);
    send_frame(8, 12, 5, 6);
    check("t3_relocked", 32'(vif_p.timing_locked), 1);
    check_meas("t3_new", 8, 12, 5, 6);
    check("t3_tc_final", tc_cnt - tc0, 1);

    // 6: reset asserted in the VSync line after VSync ends, before HSync
    fork
      send_frame(8, 12, 5, 6);
      begin
        repeat (6) @(posedge PixelClk);
        #3 aRst_n = 1'b0;
        #1;
        check("t6_rst_locked", 32'(vif_p.timing_locked), 0);
        check("t6_rst_odata", 32'(vif_p.vid_oData), 0);
        check_meas("t6_rst", 0, 0, 0, 0);
        @(posedge PixelClk);
        #3 aRst_n = 1'b1;
      end
    join
    send_frame(8, 12, 5, 6);
    send_frame(8, 12, 5, 6);
    check("t6_not_yet", 32'(vif_p.timing_locked), 0);
    send_frame(8, 12, 5, 6);
    check("t6_relocked", 32'(vif_p.timing_locked), 1);
    check_meas("t6", 8, 12, 5, 6);

    // 5: VDE held low; watchdog drops lock once, video keeps flowing
    tc0 = tc_cnt;
    passthru(4095, 1'b0);
    check("t5_unlocked", 32'(vif_p.timing_locked), 0);
    check("t5_tc_count", tc_cnt - tc0, 1);
    check_meas("t5_hold", 8, 12, 5, 6);
    passthru(64, 1'b0);
    check("t5_tc_once", tc_cnt - tc0, 1);

    // 4: 720p line timing with a short vertical so the run stays brief
    for (int f = 0; f < 3; f++) send_frame(1280, 1650, 2, 3);
    check("t4_not_yet_n", 32'(vif_n.timing_locked), 0);
    send_frame(1280, 1650, 2, 3);
    check("t4_locked_n", 32'(vif_n.timing_locked), 1);
    check("t4_hact_n", 32'(vif_n.h_active), 1280);
    check("t4_htot_n", 32'(vif_n.h_total), 1650);
    check("t4_vact_n", 32'(vif_n.v_active), 2);
    check("t4_vtot_n", 32'(vif_n.v_total), 3);
    check("t4_locked_p", 32'(vif_p.timing_locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
